// File: rtl/rv32_trap_pkg.sv
// Shared definitions for the machine-mode trap unit: exception bundle bit
// positions, CSR addresses, cause codes, controller state and mtvec legalisation.
package rv32_trap_pkg;

  // Layout of the decode stage's exceptions bundle.
  localparam int unsigned EXCEPTION_WIDTH   = 4;
  localparam int unsigned EXCEPTION_ILLEGAL = 0;
  localparam int unsigned EXCEPTION_ECALL   = 1;
  localparam int unsigned EXCEPTION_EBREAK  = 2;
  localparam int unsigned EXCEPTION_MRET    = 3;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Cause codes without the interrupt flag (bit 31 of mcause).
  localparam logic [4:0] CAUSE_ILLEGAL    = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;
  localparam logic [4:0] IRQ_M_TIMER      = 5'd7;
  localparam logic [4:0] IRQ_M_EXT        = 5'd11;

  typedef enum logic [0:0] {
    TRAP_RUN,
    TRAP_REDIRECT
  } trap_state_e;

  // mtvec mode is WARL: only direct (00) or, when enabled, vectored (01) survive.
  function automatic logic [31:0] mtvec_legalize(logic [31:0] value, bit vectored_en);
    return {value[31:2], (vectored_en && value[1:0] == 2'b01) ? 2'b01 : 2'b00};
  endfunction

endpackage

// File: rtl/rv32_t_cause_encoder.sv
// Combinational priority encoder for trap entry.
//   valid_i / exceptions_i / pc_i / instr_i : execute-stage instruction
//   irq_*_i, mie_*_i, mstatus_mie_i          : interrupt lines and enables
//   take_o / ret_o                           : trap entry / MRET this cycle
//   irq_o                                    : the trap being taken is an interrupt
//   cause_code_o, mcause_o, mtval_o          : values to record on entry
// Priority: ILLEGAL > EBREAK > ECALL > external irq > timer irq.
module rv32_t_cause_encoder
  import rv32_trap_pkg::*;
(
  input  logic                       valid_i,
  input  logic [EXCEPTION_WIDTH-1:0] exceptions_i,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                instr_i,
  input  logic                       irq_timer_i,
  input  logic                       irq_external_i,
  input  logic                       mie_timer_i,
  input  logic                       mie_external_i,
  input  logic                       mstatus_mie_i,
  output logic                       take_o,
  output logic                       ret_o,
  output logic                       irq_o,
  output logic [4:0]                 cause_code_o,
  output logic [31:0]                mcause_o,
  output logic [31:0]                mtval_o
);

  logic irq_ext, irq_tmr, irq_pend, exc;

  always_comb begin
    irq_ext  = mstatus_mie_i & irq_external_i & mie_external_i;
    irq_tmr  = mstatus_mie_i & irq_timer_i & mie_timer_i;
    irq_pend = irq_ext | irq_tmr;
    exc      = |exceptions_i[2:0];

    take_o = valid_i & (exc | irq_pend);
    ret_o  = valid_i & exceptions_i[EXCEPTION_MRET] & ~exc & ~irq_pend;
    irq_o  = ~exc & irq_pend;

    cause_code_o = 5'd0;
    mtval_o      = 32'h0;
    if (exceptions_i[EXCEPTION_ILLEGAL]) begin
      cause_code_o = CAUSE_ILLEGAL;
      mtval_o      = instr_i;
    end else if (exceptions_i[EXCEPTION_EBREAK]) begin
      cause_code_o = CAUSE_BREAKPOINT;
      mtval_o      = pc_i;
    end else if (exceptions_i[EXCEPTION_ECALL]) begin
      cause_code_o = CAUSE_ECALL_M;
    end else if (irq_ext) begin
      cause_code_o = IRQ_M_EXT;
    end else if (irq_tmr) begin
      cause_code_o = IRQ_M_TIMER;
    end

    mcause_o = {irq_o, 26'h0, cause_code_o};
  end

endmodule

// File: rtl/rv32_trap_controller.sv
// Machine-mode trap controller. Takes exceptions/interrupts/MRET from the
// execute stage, holds the trap CSRs and drives pipeline flush + fetch redirect.
//   clk_i, rst_n_i                 : clock, async active-low reset
//   valid_e_i, exceptions_e_i      : execute instruction and its exception bundle
//   pc_e_i, instr_e_i              : execute PC and instruction word
//   irq_timer_i, irq_external_i    : level machine interrupts
//   csr_write_i/address/write_data : CSR write port; csr_read_data_o is combinational
//   trap_flush_o                   : flush decode/execute pipe registers
//   redirect_valid_o/redirect_pc_o : fetch PC redirect (one cycle after detection)
module rv32_trap_controller
  import rv32_trap_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       valid_e_i,
  input  logic [EXCEPTION_WIDTH-1:0] exceptions_e_i,
  input  logic [31:0]                pc_e_i,
  input  logic [31:0]                instr_e_i,
  input  logic                       irq_timer_i,
  input  logic                       irq_external_i,
  input  logic                       csr_write_i,
  input  logic [11:0]                csr_address_i,
  input  logic [31:0]                csr_write_data_i,
  output logic [31:0]                csr_read_data_o,
  output logic                       trap_flush_o,
  output logic                       redirect_valid_o,
  output logic [31:0]                redirect_pc_o
);

  trap_state_e state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_timer_q, mie_timer_d;
  logic        mie_ext_q, mie_ext_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        enc_take, enc_ret, enc_irq;
  logic [4:0]  enc_code;
  logic [31:0] enc_mcause, enc_mtval;
  logic        run, take, ret;
  logic [31:0] base, target;

  rv32_t_cause_encoder u_cause_encoder (
    .valid_i        (valid_e_i),
    .exceptions_i   (exceptions_e_i),
    .pc_i           (pc_e_i),
    .instr_i        (instr_e_i),
    .irq_timer_i    (irq_timer_i),
    .irq_external_i (irq_external_i),
    .mie_timer_i    (mie_timer_q),
    .mie_external_i (mie_ext_q),
    .mstatus_mie_i  (mstatus_mie_q),
    .take_o         (enc_take),
    .ret_o          (enc_ret),
    .irq_o          (enc_irq),
    .cause_code_o   (enc_code),
    .mcause_o       (enc_mcause),
    .mtval_o        (enc_mtval)
  );

  // Trap requests are only honoured in RUN; REDIRECT ignores everything.
  assign run  = (state_q == TRAP_RUN);
  assign take = run & enc_take;
  assign ret  = run & enc_ret;

  always_comb begin
    base   = {mtvec_q[31:2], 2'b00};
    target = base;
    if (enc_irq && VECTORED_EN && mtvec_q[1:0] == 2'b01) begin
      target = base + {25'h0, enc_code, 2'b00};
    end
  end

  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_timer_d    = mie_timer_q;
    mie_ext_d      = mie_ext_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    redirect_pc_d  = redirect_pc_q;

    unique case (state_q)
      TRAP_RUN: begin
        if (take) begin
          mepc_d         = {pc_e_i[31:2], 2'b00};
          mcause_d       = enc_mcause;
          mtval_d        = enc_mtval;
          mstatus_mpie_d = mstatus_mie_q;
          mstatus_mie_d  = 1'b0;
          redirect_pc_d  = target;
          state_d        = TRAP_REDIRECT;
        end else if (ret) begin
          mstatus_mie_d  = mstatus_mpie_q;
          mstatus_mpie_d = 1'b1;
          redirect_pc_d  = mepc_q;
          state_d        = TRAP_REDIRECT;
        end else if (csr_write_i) begin
          unique case (csr_address_i)
            CSR_MSTATUS: begin
              mstatus_mie_d  = csr_write_data_i[3];
              mstatus_mpie_d = csr_write_data_i[7];
            end
            CSR_MIE: begin
              mie_timer_d = csr_write_data_i[7];
              mie_ext_d   = csr_write_data_i[11];
            end
            CSR_MTVEC:  mtvec_d  = mtvec_legalize(csr_write_data_i, VECTORED_EN);
            CSR_MEPC:   mepc_d   = {csr_write_data_i[31:2], 2'b00};
            CSR_MCAUSE: mcause_d = csr_write_data_i;
            CSR_MTVAL:  mtval_d  = csr_write_data_i;
            default: ;
          endcase
        end
      end
      TRAP_REDIRECT: state_d = TRAP_RUN;
      default:       state_d = TRAP_RUN;
    endcase
  end

  always_comb begin
    csr_read_data_o = 32'h0;
    unique case (csr_address_i)
      CSR_MSTATUS: csr_read_data_o = {19'h0, 2'b11, 3'b000, mstatus_mpie_q, 3'b000,
                                      mstatus_mie_q, 3'b000};
      CSR_MIE:     csr_read_data_o = {20'h0, mie_ext_q, 3'b000, mie_timer_q, 7'h0};
      CSR_MTVEC:   csr_read_data_o = mtvec_q;
      CSR_MEPC:    csr_read_data_o = mepc_q;
      CSR_MCAUSE:  csr_read_data_o = mcause_q;
      CSR_MTVAL:   csr_read_data_o = mtval_q;
      CSR_MIP:     csr_read_data_o = {20'h0, irq_external_i, 3'b000, irq_timer_i, 7'h0};
      default:     csr_read_data_o = 32'h0;
    endcase
  end

  assign trap_flush_o     = take | ret | (state_q == TRAP_REDIRECT);
  assign redirect_valid_o = (state_q == TRAP_REDIRECT);
  assign redirect_pc_o    = redirect_pc_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= TRAP_RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_timer_q    <= 1'b0;
      mie_ext_q      <= 1'b0;
      mtvec_q        <= RESET_MTVEC;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtval_q        <= 32'h0;
      redirect_pc_q  <= 32'h0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_timer_q    <= mie_timer_d;
      mie_ext_q      <= mie_ext_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_rv32_trap_controller.sv
// Directed, table-driven bench for rv32_trap_controller.
module tb_rv32_trap_controller;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_e_i = 1'b0;
  logic [3:0]  exceptions_e_i = 4'h0;
  logic [31:0] pc_e_i = 32'h0;
  logic [31:0] instr_e_i = 32'h0;
  logic        irq_timer_i = 1'b0;
  logic        irq_external_i = 1'b0;
  logic        csr_write_i = 1'b0;
  logic [11:0] csr_address_i = 12'h0;
  logic [31:0] csr_write_data_i = 32'h0;
  logic [31:0] csr_read_data_o;
  logic        trap_flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  int checks = 0;
  int failures = 0;

  rv32_trap_controller dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .valid_e_i        (valid_e_i),
    .exceptions_e_i   (exceptions_e_i),
    .pc_e_i           (pc_e_i),
    .instr_e_i        (instr_e_i),
    .irq_timer_i      (irq_timer_i),
    .irq_external_i   (irq_external_i),
    .csr_write_i      (csr_write_i),
    .csr_address_i    (csr_address_i),
    .csr_write_data_i (csr_write_data_i),
    .csr_read_data_o  (csr_read_data_o),
    .trap_flush_o     (trap_flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] mie_w, mstatus_w, mtvec_w, mepc_w;
    logic        valid;
    logic [3:0]  exc;
    logic [31:0] pc, instr;
    logic        irq_t, irq_e;
    logic        exp_redir;
    logic [31:0] exp_pc;
    logic        chk_cause;
    logic [31:0] exp_mepc, exp_mcause, exp_mtval, exp_mstatus;
  } vec_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } csr_vec_t;

  vec_t     vecs[11];
  csr_vec_t cvecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    csr_write_i = 1'b1;
    csr_address_i = addr;
    csr_write_data_i = data;
    @(negedge clk_i);
    csr_write_i = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] addr, output logic [31:0] data);
    csr_address_i = addr;
    #1;
    data = csr_read_data_o;
  endtask

  task automatic clear_inputs();
    valid_e_i = 1'b0;
    exceptions_e_i = 4'h0;
    irq_timer_i = 1'b0;
    irq_external_i = 1'b0;
    csr_write_i = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    // name, mie, mstatus, mtvec, mepc, valid, exc, pc, instr, irq_t, irq_e,
    // exp_redir, exp_pc, chk_cause, exp_mepc, exp_mcause, exp_mtval, exp_mstatus
    vecs[0]  = '{"ecall", 32'h0, 32'h8, 32'h200, 32'h0, 1'b1, 4'b0010, 32'h100, 32'h73,
                 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 32'hB, 32'h0, 32'h1880};
    vecs[1]  = '{"illegal", 32'h0, 32'h0, 32'h200, 32'h0, 1'b1, 4'b0001, 32'h40, 32'hFFFF_FFFF,
                 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h40, 32'h2, 32'hFFFF_FFFF, 32'h1800};
    vecs[2]  = '{"ebreak", 32'h0, 32'h0, 32'h200, 32'h0, 1'b1, 4'b0100, 32'h44, 32'h0010_0073,
                 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h44, 32'h3, 32'h44, 32'h1800};
    vecs[3]  = '{"irq_both", 32'h880, 32'h8, 32'h1001, 32'h0, 1'b1, 4'b0000, 32'h300, 32'h13,
                 1'b1, 1'b1, 1'b1, 32'h102C, 1'b1, 32'h300, 32'h8000_000B, 32'h0, 32'h1880};
    vecs[4]  = '{"irq_bubble", 32'h880, 32'h8, 32'h1001, 32'h0, 1'b0, 4'b0000, 32'h300, 32'h13,
                 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1808};
    vecs[5]  = '{"ecall_vs_timer", 32'h80, 32'h8, 32'h1001, 32'h0, 1'b1, 4'b0010, 32'h208, 32'h73,
                 1'b1, 1'b0, 1'b1, 32'h1000, 1'b1, 32'h208, 32'hB, 32'h0, 32'h1880};
    vecs[6]  = '{"timer_vec", 32'h80, 32'h8, 32'h1001, 32'h0, 1'b1, 4'b0000, 32'h50, 32'h13,
                 1'b1, 1'b0, 1'b1, 32'h101C, 1'b1, 32'h50, 32'h8000_0007, 32'h0, 32'h1880};
    vecs[7]  = '{"irq_masked", 32'h0, 32'h8, 32'h1001, 32'h0, 1'b1, 4'b0000, 32'h60, 32'h13,
                 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1808};
    vecs[8]  = '{"mret", 32'h0, 32'h80, 32'h200, 32'h104, 1'b1, 4'b1000, 32'h70, 32'h3020_0073,
                 1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1888};
    vecs[9]  = '{"ecall_misaligned", 32'h0, 32'h0, 32'h200, 32'h0, 1'b1, 4'b0010, 32'h103, 32'h73,
                 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 32'hB, 32'h0, 32'h1800};
    vecs[10] = '{"mret_vs_irq", 32'h800, 32'h8, 32'h200, 32'h0, 1'b1, 4'b1000, 32'h80, 32'h13,
                 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h80, 32'h8000_000B, 32'h0, 32'h1880};

    cvecs[0] = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
    cvecs[1] = '{12'h305, 32'h0000_0003, 32'h0000_0000};
    cvecs[2] = '{12'h305, 32'h0000_1001, 32'h0000_1001};
    cvecs[3] = '{12'h305, 32'h0000_1002, 32'h0000_1000};
    cvecs[4] = '{12'h341, 32'h0000_0107, 32'h0000_0104};
    cvecs[5] = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0880};
    cvecs[6] = '{12'h7FF, 32'hFFFF_FFFF, 32'h0000_0000};

    // Reset state
    #12;
    check("rst_flush", {31'h0, trap_flush_o}, 32'h0);
    check("rst_redirect_valid", {31'h0, redirect_valid_o}, 32'h0);
    check("rst_redirect_pc", redirect_pc_o, 32'h0);
    csr_rd(12'h300, rd); check("rst_mstatus", rd, 32'h1800);
    csr_rd(12'h305, rd); check("rst_mtvec", rd, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // CSR write/readback table
    for (int i = 0; i < 7; i++) begin
      csr_wr(cvecs[i].addr, cvecs[i].wdata);
      csr_rd(cvecs[i].addr, rd);
      check($sformatf("csr_%03h_%0d", cvecs[i].addr, i), rd, cvecs[i].exp);
    end
    csr_wr(12'h300, 32'h0);
    irq_external_i = 1'b1;
    csr_rd(12'h344, rd); check("mip_ext", rd, 32'h800);
    irq_timer_i = 1'b1;
    csr_rd(12'h344, rd); check("mip_both", rd, 32'h880);
    clear_inputs();

    // Trap table
    for (int i = 0; i < 11; i++) begin
      csr_wr(12'h304, vecs[i].mie_w);
      csr_wr(12'h305, vecs[i].mtvec_w);
      csr_wr(12'h341, vecs[i].mepc_w);
      csr_wr(12'h300, vecs[i].mstatus_w);
      @(negedge clk_i);
      valid_e_i = vecs[i].valid;
      exceptions_e_i = vecs[i].exc;
      pc_e_i = vecs[i].pc;
      instr_e_i = vecs[i].instr;
      irq_timer_i = vecs[i].irq_t;
      irq_external_i = vecs[i].irq_e;
      #1;
      check({vecs[i].name, "_flush_T"}, {31'h0, trap_flush_o}, {31'h0, vecs[i].exp_redir});
      @(negedge clk_i);
      clear_inputs();
      #1;
      check({vecs[i].name, "_redir_valid"}, {31'h0, redirect_valid_o},
            {31'h0, vecs[i].exp_redir});
      check({vecs[i].name, "_flush_T1"}, {31'h0, trap_flush_o}, {31'h0, vecs[i].exp_redir});
      if (vecs[i].exp_redir) check({vecs[i].name, "_redir_pc"}, redirect_pc_o, vecs[i].exp_pc);
      @(negedge clk_i);
      #1;
      check({vecs[i].name, "_redir_drop"}, {31'h0, redirect_valid_o}, 32'h0);
      csr_rd(12'h300, rd); check({vecs[i].name, "_mstatus"}, rd, vecs[i].exp_mstatus);
      if (vecs[i].chk_cause) begin
        csr_rd(12'h341, rd); check({vecs[i].name, "_mepc"}, rd, vecs[i].exp_mepc);
        csr_rd(12'h342, rd); check({vecs[i].name, "_mcause"}, rd, vecs[i].exp_mcause);
        csr_rd(12'h343, rd); check({vecs[i].name, "_mtval"}, rd, vecs[i].exp_mtval);
      end
    end

    // CSR write coincident with ECALL, and one during REDIRECT, are both dropped
    csr_wr(12'h305, 32'h200);
    csr_wr(12'h300, 32'h0);
    @(negedge clk_i);
    valid_e_i = 1'b1; exceptions_e_i = 4'b0010; pc_e_i = 32'h10;
    csr_write_i = 1'b1; csr_address_i = 12'h305; csr_write_data_i = 32'h400;
    @(negedge clk_i);
    clear_inputs();
    csr_write_i = 1'b1; csr_address_i = 12'h341; csr_write_data_i = 32'h55C;
    #1;
    check("wr_drop_redir_pc", redirect_pc_o, 32'h200);
    @(negedge clk_i);
    csr_write_i = 1'b0;
    csr_rd(12'h305, rd); check("wr_drop_mtvec", rd, 32'h200);
    csr_rd(12'h341, rd); check("wr_drop_mepc", rd, 32'h10);

    // Held ECALL: REDIRECT ignores it, next RUN cycle takes it again
    @(negedge clk_i);
    valid_e_i = 1'b1; exceptions_e_i = 4'b0010; pc_e_i = 32'h20;
    @(negedge clk_i);
    #1 check("b2b_first_redir", {31'h0, redirect_valid_o}, 32'h1);
    @(negedge clk_i);
    #1 check("b2b_gap_redir", {31'h0, redirect_valid_o}, 32'h0);
    check("b2b_gap_flush", {31'h0, trap_flush_o}, 32'h1);
    @(negedge clk_i);
    clear_inputs();
    #1 check("b2b_second_redir", {31'h0, redirect_valid_o}, 32'h1);
    @(negedge clk_i);

    // Reset pulse while in REDIRECT
    @(negedge clk_i);
    valid_e_i = 1'b1; exceptions_e_i = 4'b0010; pc_e_i = 32'h30;
    @(negedge clk_i);
    clear_inputs();
    #1 check("rstr_redir_before", {31'h0, redirect_valid_o}, 32'h1);
    rst_n_i = 1'b0;
    #1;
    check("rstr_redir_valid", {31'h0, redirect_valid_o}, 32'h0);
    check("rstr_flush", {31'h0, trap_flush_o}, 32'h0);
    check("rstr_redir_pc", redirect_pc_o, 32'h0);
    csr_rd(12'h305, rd); check("rstr_mtvec", rd, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    #1 check("rstr_after_redir", {31'h0, redirect_valid_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_trap_controller.md
Name: rv32_trap_controller

Overview:
- Machine-mode trap unit and consumer of the decode stage's registered `exceptions_o` bundle, taken when the instruction reaches execute.
- Takes exceptions, interrupts and MRET. Holds the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause, mtval).
- Drives the pipeline flush (`flush_e_i` side of decode) and the fetch PC redirect.
- Sits beside the execute stage; a CSR read/write port serves the CSR datapath.

Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec.
- VECTORED_EN, 1, 1 = honour mtvec mode 01 (vectored interrupts); 0 = mode forced to direct.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- valid_e_i  in  1  execute stage holds a real (non-bubble) instruction
- exceptions_e_i  in  `EXCEPTION_WIDTH (4)  bit0 ILLEGAL, bit1 ECALL, bit2 EBREAK, bit3 MRET
- pc_e_i  in  32  PC of execute instruction
- instr_e_i  in  32  instruction word in execute
- irq_timer_i  in  1  level machine timer interrupt
- irq_external_i  in  1  level machine external interrupt
- csr_write_i  in  1  CSR write request from execute
- csr_address_i  in  12  CSR address (read and write)
- csr_write_data_i  in  32  CSR write data
- csr_read_data_o  out  32  combinational CSR read data
- trap_flush_o  out  1  flush decode/execute pipe registers
- redirect_valid_o  out  1  load fetch PC with redirect_pc_o
- redirect_pc_o  out  32  redirect target

Behaviour:

Reset:
- State RUN.
- mstatus.MIE = 0, mstatus.MPIE = 0, mie = 0, mtvec = RESET_MTVEC, mepc = mcause = mtval = 0.
- All outputs 0. redirect_pc_o = 0.
- Reset asserted in any state returns to RUN immediately; an in-flight redirect is dropped.

Definitions:
- `irq_pend` = mstatus.MIE & ((irq_external_i & mie[11]) | (irq_timer_i & mie[7])).
- `exc` = |exceptions_e_i[2:0].
- `take` = valid_e_i & (exc | irq_pend).
- `ret` = valid_e_i & exceptions_e_i[3] & !exc & !irq_pend.

Priority, and mcause / mtval / mepc per case:
- ILLEGAL: cause 2, mtval = instr_e_i.
- EBREAK: cause 3, mtval = pc_e_i.
- ECALL: cause 11, mtval = 0.
- Synchronous exceptions beat interrupts.
- External interrupt: mcause 32'h8000_000B. Timer interrupt: mcause 32'h8000_0007. External beats timer. mtval = 0.
- mepc = {pc_e_i[31:2], 2'b00} for all cases; on an interrupt the execute instruction is not committed.

State RUN, cycle T with `take`:
- trap_flush_o = 1 combinationally in T.
- At edge T+1: mepc, mcause and mtval load; MPIE <= MIE; MIE <= 0; state becomes REDIRECT.
- redirect register loads `base` = {mtvec[31:2], 2'b00}.
- Exception: target = base.
- Interrupt with mtvec[1:0] = 01 and VECTORED_EN: target = base + 4*cause.

State RUN, cycle T with `ret`:
- trap_flush_o = 1 in T.
- At edge T+1: MIE <= MPIE, MPIE <= 1, redirect register <= mepc, state becomes REDIRECT.

State REDIRECT (exactly one cycle):
- redirect_valid_o = 1 and trap_flush_o = 1.
- exceptions_e_i, irqs and csr_write_i are ignored.
- Next state RUN.
- Latency: detection to redirect_valid_o is 1 cycle; back-to-back traps are spaced at least 2 cycles.

CSR port:
- A write commits at the clock edge only in RUN with no take/ret in that cycle; otherwise it is dropped.
- Addresses: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344.
- mstatus: only bits 3 (MIE) and 7 (MPIE) are writable; MPP[12:11] reads 2'b11; all else reads 0.
- mie: bits 7 and 11 writable.
- mip: read-only, {irq_external_i at 11, irq_timer_i at 7}.
- mtvec: mode field [1:0] is WARL. Values 1x store 00; 01 stores 00 when VECTORED_EN = 0.
- mepc: bits [1:0] forced 0.
- Unknown address reads 0; writes to it are ignored.
- A CSR write to mstatus.MIE takes effect for `irq_pend` the next cycle.
- valid_e_i = 0 blocks all trap entry (no interrupt is taken on a bubble).

Decomposition:
- Package rv32_trap_pkg:
  - CSR address constants.
  - Cause codes (CAUSE_ILLEGAL = 2, CAUSE_BREAKPOINT = 3, CAUSE_ECALL_M = 11, IRQ_M_TIMER = 7, IRQ_M_EXT = 11).
  - State enum {TRAP_RUN, TRAP_REDIRECT}.
  - Exception bit indices, taken from the existing EXCEPTION_* defines.
- One sub-module, rv32_t_cause_encoder: combinational priority encoder producing take, ret, mcause and mtval.

Test Plan:
- ECALL at pc 0x0000_0100, mtvec = 0x0000_0200, MIE = 1: flush in T; at T+1 redirect to 0x200; mepc = 0x100, mcause = 11, MIE = 0, MPIE = 1.
- ILLEGAL, instr 0xFFFF_FFFF at pc 0x40: mtval = 0xFFFF_FFFF, mcause = 2. EBREAK at pc 0x44: mtval = 0x44, mcause = 3.
- mtvec = 0x0000_1001, mie = 0x880, MIE = 1, both irqs high, valid_e_i = 1: mcause = 0x8000_000B, redirect 0x102C. Repeat with valid_e_i = 0: no trap.
- MRET with mepc = 0x104, MPIE = 1: redirect 0x104; MIE = 1, MPIE = 1. ECALL and timer irq together: ECALL wins, mcause = 11.
- CSR writes:
  - 0xFFFF_FFFF to mstatus reads back 0x0000_1888.
  - 0x0000_0003 to mtvec reads back 0x0000_0000.
  - 0x0000_0107 to mepc reads back 0x0000_0104.
  - A csr_write_i in the same cycle as an ECALL is dropped.
- Reset pulse during REDIRECT: redirect_valid_o and trap_flush_o go 0 immediately; mtvec = RESET_MTVEC.
